// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   - FSM state encoding
//   - operand-forwarding select encoding and a priority helper
//   - default register-number and counter widths
package pipe_ctrl_pkg;

    localparam int unsigned DEF_REGNOBITS = 4;
    localparam int unsigned DEF_CNTBITS   = 32;
    localparam int unsigned FWDBITS       = 2;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_CTRL_WAIT = 2'd1,
        ST_REDIRECT  = 2'd2
    } state_t;

    localparam logic [FWDBITS-1:0] FWD_REG = 2'd0;
    localparam logic [FWDBITS-1:0] FWD_EX  = 2'd1;
    localparam logic [FWDBITS-1:0] FWD_MEM = 2'd2;

    // Youngest producer wins: EX result is newer than MEM result.
    function automatic logic [FWDBITS-1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit)       return FWD_EX;
        else if (mem_hit) return FWD_MEM;
        else              return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker for the EX and MEM stages plus RAW match logic.
// The WB entry is not stored: the regfile writes on negedge, so a WB producer
// is already visible to ID and can never cause a hazard or need forwarding.
// Build option: PIPE_FORWARDING_EN (load-use-only hazards, forwarding selects).
// Ports:
//   clk, reset            clock, async active-high reset (clears all entries)
//   in_valid/in_wregno/in_is_load  entry shifting into EX this cycle
//   rs, rt                source registers of the instruction in ID
//   hz_rs, hz_rt          source needs a stall
//   fwd_rs, fwd_rt        forwarding select for each source
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REGNOBITS = DEF_REGNOBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [REGNOBITS-1:0] in_wregno,
    input  logic                 in_is_load,
    input  logic [REGNOBITS-1:0] rs,
    input  logic [REGNOBITS-1:0] rt,
    output logic                 hz_rs,
    output logic                 hz_rt,
    output logic [FWDBITS-1:0]   fwd_rs,
    output logic [FWDBITS-1:0]   fwd_rt
);

    logic                 ex_valid, mem_valid;
    logic [REGNOBITS-1:0] ex_wregno, mem_wregno;
    logic                 ex_load;
    logic                 ex_hit_rs, mem_hit_rs, ex_hit_rt, mem_hit_rt;

    // EX -> MEM shift, one step per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_wregno  <= '0;
            ex_load    <= 1'b0;
            mem_valid  <= 1'b0;
            mem_wregno <= '0;
        end else begin
            ex_valid   <= in_valid;
            ex_wregno  <= in_wregno;
            ex_load    <= in_is_load;
            mem_valid  <= ex_valid;
            mem_wregno <= ex_wregno;
        end
    end

    assign ex_hit_rs  = ex_valid  & (ex_wregno  == rs);
    assign mem_hit_rs = mem_valid & (mem_wregno == rs);
    assign ex_hit_rt  = ex_valid  & (ex_wregno  == rt);
    assign mem_hit_rt = mem_valid & (mem_wregno == rt);

`ifdef PIPE_FORWARDING_EN
    // Only a load in EX has no result yet; everything else is forwarded.
    assign hz_rs  = ex_hit_rs & ex_load;
    assign hz_rt  = ex_hit_rt & ex_load;
    assign fwd_rs = fwd_pick(ex_hit_rs, mem_hit_rs);
    assign fwd_rt = fwd_pick(ex_hit_rt, mem_hit_rt);
`else
    logic unused_load;
    assign unused_load = ex_load;
    assign hz_rs  = ex_hit_rs | mem_hit_rs;
    assign hz_rt  = ex_hit_rt | mem_hit_rt;
    assign fwd_rs = FWD_REG;
    assign fwd_rt = FWD_REG;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the FE/ID/EX/MEM/WB pipeline.
// Build option: PIPE_FORWARDING_EN enables forwarding selects and limits
// stalls to load-use; without it any EX/MEM producer stalls ID.
// Ports:
//   clk, reset            clock, async active-high reset
//   id_*                  decode info for the instruction in ID
//   ex_resolve/ex_mispred control instruction in EX resolved / mispredicted
//   stall_fe              hold PC and FE latch
//   bubble_id             insert NOP into ID->EX
//   flush_fe              squash FE latch, select pcgood
//   fwd_rs_sel/fwd_rt_sel operand source (regfile, EX, MEM)
//   stall_cnt/flush_cnt   debug event counters (wrap)
// Control outputs are combinational (they must act in the cycle the hazard is
// seen) and forced to 0 while reset is asserted.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REGNOBITS = DEF_REGNOBITS,
    parameter int unsigned CNTBITS   = DEF_CNTBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REGNOBITS-1:0] id_rs,
    input  logic [REGNOBITS-1:0] id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic                 id_wr_reg,
    input  logic [REGNOBITS-1:0] id_wregno,
    input  logic                 id_is_load,
    input  logic                 id_is_ctrl,
    input  logic                 ex_resolve,
    input  logic                 ex_mispred,
    output logic                 stall_fe,
    output logic                 bubble_id,
    output logic                 flush_fe,
    output logic [FWDBITS-1:0]   fwd_rs_sel,
    output logic [FWDBITS-1:0]   fwd_rt_sel,
    output logic [CNTBITS-1:0]   stall_cnt,
    output logic [CNTBITS-1:0]   flush_cnt
);

    state_t               state, state_nxt;
    logic                 sb_in_valid;
    logic                 hz_rs, hz_rt, hz;
    logic [FWDBITS-1:0]   sb_fwd_rs, sb_fwd_rt;

    // A bubbled instruction never reaches EX, so it must not enter the scoreboard.
    assign sb_in_valid = id_valid & id_wr_reg & ~bubble_id;

    hazard_scoreboard #(
        .REGNOBITS (REGNOBITS)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (sb_in_valid),
        .in_wregno  (id_wregno),
        .in_is_load (id_is_load),
        .rs         (id_rs),
        .rt         (id_rt),
        .hz_rs      (hz_rs),
        .hz_rt      (hz_rt),
        .fwd_rs     (sb_fwd_rs),
        .fwd_rt     (sb_fwd_rt)
    );

    assign hz = id_valid & ((id_use_rs & hz_rs) | (id_use_rt & hz_rt));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // Next state and control outputs; a hazard stall beats a control instruction.
    always_comb begin
        state_nxt  = state;
        stall_fe   = 1'b0;
        bubble_id  = 1'b0;
        flush_fe   = 1'b0;
        fwd_rs_sel = FWD_REG;
        fwd_rt_sel = FWD_REG;
        if (!reset) begin
            fwd_rs_sel = sb_fwd_rs;
            fwd_rt_sel = sb_fwd_rt;
            case (state)
                ST_RUN: begin
                    if (hz) begin
                        stall_fe  = 1'b1;
                        bubble_id = 1'b1;
                    end else if (id_valid && id_is_ctrl) begin
                        stall_fe  = 1'b1;
                        state_nxt = ST_CTRL_WAIT;
                    end
                end
                ST_CTRL_WAIT: begin
                    stall_fe  = 1'b1;
                    bubble_id = 1'b1;
                    if (ex_resolve) state_nxt = ex_mispred ? ST_REDIRECT : ST_RUN;
                end
                ST_REDIRECT: begin
                    flush_fe  = 1'b1;
                    bubble_id = 1'b1;
                    state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    // Debug event counters, wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_fe) stall_cnt <= stall_cnt + CNTBITS'(1);
            if (flush_fe) flush_cnt <= flush_cnt + CNTBITS'(1);
        end
    end

endmodule
